// File: rtl/cpu64_iter_divider_pkg.sv
// Shared definitions for the iterative radix-2 unsigned divider.
package cpu64_iter_divider_pkg;

    localparam int XLEN = 64;
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] NEGATIVE_1 = '1;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/cpu64_div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract D, restore on borrow.
module cpu64_div_step
    import cpu64_iter_divider_pkg::*;
(
    input  logic [XLEN-1:0] r_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] d_i,
    output logic [XLEN-1:0] r_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // R < D before the shift, so the new R always fits back into XLEN bits.
    always_comb begin
        shifted = {r_i, q_i[XLEN-1]};
        trial   = shifted - {1'b0, d_i};
        q_o     = {q_i[XLEN-2:0], ~trial[XLEN]};
        r_o     = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    end

endmodule

// File: rtl/cpu64_iter_divider.sv
// Iterative radix-2 restoring unsigned divider: one quotient bit per cycle,
// one-cycle done pulse, RISC-V divide-by-zero results.
module cpu64_iter_divider
    import cpu64_iter_divider_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            req_i,
    input  logic            kill_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            done_o,
    output logic            busy_o
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  r_q;
    logic [XLEN-1:0]  q_q;
    logic [XLEN-1:0]  d_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  rem_q;
    logic             done_q;
    logic             busy_q;

    logic [XLEN-1:0]  r_d;
    logic [XLEN-1:0]  q_d;

    cpu64_div_step u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_d),
        .q_o (q_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DIV_ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            case (state_q)
                DIV_ST_IDLE, DIV_ST_DONE: begin
                    state_q <= DIV_ST_IDLE;
                    if (req_i) begin
                        if (op_b_i == '0) begin
                            state_q <= DIV_ST_DONE;
                            done_q  <= 1'b1;
                            quot_q  <= NEGATIVE_1;
                            rem_q   <= op_a_i;
                        end else begin
                            state_q <= DIV_ST_BUSY;
                            busy_q  <= 1'b1;
                            d_q     <= op_b_i;
                            q_q     <= op_a_i;
                            r_q     <= '0;
                            cnt_q   <= CNT_W'(XLEN - 1);
                        end
                    end
                end
                DIV_ST_BUSY: begin
                    // A flush drops the op silently; the last published result stays put.
                    if (kill_i) begin
                        state_q <= DIV_ST_IDLE;
                    end else begin
                        r_q   <= r_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= DIV_ST_DONE;
                            done_q  <= 1'b1;
                            quot_q  <= q_d;
                            rem_q   <= r_d;
                        end else begin
                            busy_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= DIV_ST_IDLE;
            endcase
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_cpu64_iter_divider.sv
// Directed bench for cpu64_iter_divider: vector table plus handshake corner sequences.
module tb_cpu64_iter_divider;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [63:0] op_a_i = '0;
    logic [63:0] op_b_i = '0;
    logic        req_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [63:0] quotient_o;
    logic [63:0] remainder_o;
    logic        done_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    logic [63:0] mid_q, mid_r, prev_q, prev_r;

    cpu64_iter_divider dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .req_i       (req_i),
        .kill_i      (kill_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents a request for one cycle, then scrambles the operands.
    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        op_a_i = a;
        op_b_i = b;
        req_i  = 1'b1;
        tick();
        req_i  = 1'b0;
        op_a_i = ~a;
        op_b_i = ~b;
    endtask

    task automatic wait_done(input int limit, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!done_o && n < limit) begin
            if (busy_o) nbusy++;
            if (n == 8) begin
                mid_q = quotient_o;
                mid_r = remainder_o;
            end
            tick();
            n++;
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            if (done_o) cnt++;
            tick();
        end
    endtask

    initial begin
        int n, nb, nd;

        vecs[0] = '{64'd100, 64'd7, 64'd14, 64'd2, 65};
        vecs[1] = '{64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};
        vecs[3] = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd5, 65};
        vecs[4] = '{64'd0, 64'd3, 64'd0, 64'd0, 65};
        vecs[5] = '{64'd1000000007, 64'd13, 64'd76923077, 64'd6, 65};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 65};
        vecs[7] = '{64'd3, 64'd10, 64'd0, 64'd3, 65};
        vecs[8] = '{64'd77, 64'd77, 64'd1, 64'd0, 65};
        vecs[9] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};

        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_q", quotient_o, 64'd0);
        chk("reset_r", remainder_o, 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        prev_q = '0;
        prev_r = '0;
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(200, n, nb);
            chk($sformatf("vec%0d_q", i), quotient_o, vecs[i].q);
            chk($sformatf("vec%0d_r", i), remainder_o, vecs[i].r);
            chk($sformatf("vec%0d_lat", i), 64'(1 + n), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_busycyc", i), 64'(nb), 64'(vecs[i].lat - 1));
            chk($sformatf("vec%0d_busy_in_done", i), 64'(busy_o), 64'd0);
            if (vecs[i].b != 64'd0) begin
                chk($sformatf("vec%0d_mid_q_hold", i), mid_q, prev_q);
                chk($sformatf("vec%0d_mid_r_hold", i), mid_r, prev_r);
            end
            tick();
            chk($sformatf("vec%0d_done_drop", i), 64'(done_o), 64'd0);
            chk($sformatf("vec%0d_q_held", i), quotient_o, vecs[i].q);
            prev_q = vecs[i].q;
            prev_r = vecs[i].r;
        end

        // Back-to-back: second request lands in the done cycle of the first.
        issue(64'd100, 64'd7);
        wait_done(200, n, nb);
        chk("b2b_first_q", quotient_o, 64'd14);
        chk("b2b_first_r", remainder_o, 64'd2);
        chk("b2b_first_done", 64'(done_o), 64'd1);
        issue(64'd9, 64'd2);
        chk("b2b_done_drop", 64'(done_o), 64'd0);
        chk("b2b_busy", 64'(busy_o), 64'd1);
        chk("b2b_hold_q", quotient_o, 64'd14);
        repeat (19) tick();
        op_a_i = 64'd50;
        op_b_i = 64'd3;
        req_i  = 1'b1;
        tick();
        req_i  = 1'b0;
        wait_done(200, n, nb);
        chk("b2b_second_lat", 64'(21 + n), 64'd65);
        chk("b2b_second_q", quotient_o, 64'd4);
        chk("b2b_second_r", remainder_o, 64'd1);
        tick();
        chk("b2b_idle_busy", 64'(busy_o), 64'd0);
        count_done(80, nd);
        chk("b2b_no_queued_done", 64'(nd), 64'd0);

        // Kill in cycle 30.
        issue(64'd1000, 64'd3);
        repeat (29) tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kill_busy", 64'(busy_o), 64'd0);
        chk("kill_done", 64'(done_o), 64'd0);
        chk("kill_q_kept", quotient_o, 64'd4);
        chk("kill_r_kept", remainder_o, 64'd1);
        count_done(80, nd);
        chk("kill_no_done", 64'(nd), 64'd0);
        issue(64'd100, 64'd7);
        wait_done(200, n, nb);
        chk("post_kill_lat", 64'(1 + n), 64'd65);
        chk("post_kill_q", quotient_o, 64'd14);
        chk("post_kill_r", remainder_o, 64'd2);
        // req and kill together in the done cycle: req wins.
        kill_i = 1'b1;
        issue(64'd9, 64'd2);
        kill_i = 1'b0;
        wait_done(200, n, nb);
        chk("reqkill_lat", 64'(1 + n), 64'd65);
        chk("reqkill_q", quotient_o, 64'd4);
        chk("reqkill_r", remainder_o, 64'd1);
        tick();

        // Asynchronous reset mid-operation, between clock edges.
        issue(64'd100, 64'd7);
        repeat (39) tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_mid_q", quotient_o, 64'd0);
        chk("rst_mid_r", remainder_o, 64'd0);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        chk("rst_mid_done", 64'(done_o), 64'd0);
        #2 rst_ni = 1'b1;
        count_done(80, nd);
        chk("rst_no_done", 64'(nd), 64'd0);
        chk("rst_idle_busy", 64'(busy_o), 64'd0);
        issue(64'd9, 64'd2);
        wait_done(200, n, nb);
        chk("post_rst_lat", 64'(1 + n), 64'd65);
        chk("post_rst_q", quotient_o, 64'd4);
        chk("post_rst_r", remainder_o, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
